// File: rtl/register_file_if.sv
// register_file_if: decode/writeback side of the RV32I register file.
//   write      - write-port enable
//   rd         - write-port register index
//   reg_write  - write data
//   rs1, rs2   - read-port register indices
//   reg1, reg2 - read-port data (combinational from rs1/rs2)
// master: the core driving indices and write data. slave: the register file.
interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] reg_write;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] reg1;
    logic [DATA_WIDTH-1:0] reg2;

    modport master (
        output write, rd, reg_write, rs1, rs2,
        input  reg1, reg2
    );

    modport slave (
        input  write, rd, reg_write, rs1, rs2,
        output reg1, reg2
    );
endinterface

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH general-purpose registers.
//   clk  - system clock, writes commit on the rising edge
//   rst  - asynchronous active-low reset, clears every register
//   bus  - register_file_if.slave: one synchronous write port
//          (write/rd/reg_write), two combinational read ports
//          (rs1->reg1, rs2->reg2)
// x0 reads as zero and ignores writes. There is no write-to-read bypass:
// a read of the register being written shows the old value until the edge.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_d;

    // Write decode. Entry 0 is never loaded, so it stays at its reset value.
    always_comb begin
        regs_d = regs_q;
        if (bus.write && (bus.rd != '0)) begin
            regs_d[bus.rd] = bus.reg_write;
        end
    end

    // Reset clears the array asynchronously; a write pending in the same
    // cycle is lost because the flops are held in reset through the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 is forced to zero on the read side as well, so x0 reads zero
    // independent of the storage contents.
    assign bus.reg1 = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
    assign bus.reg2 = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    logic clk;
    logic rst;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    // Monitor: whenever the stimulus marks the read ports as settled,
    // pop every pending expectation and compare against the live outputs.
    initial begin
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                if (bus.reg1 !== e.e1 || bus.reg2 !== e.e2) begin
                    bad++;
                    $display("FAIL %s: reg1=%h reg2=%h expected reg1=%h reg2=%h",
                             e.name, bus.reg1, bus.reg2, e.e1, e.e2);
                end
            end
        end
    end

    // Push an expectation for the current read indices and hand it to the monitor.
    task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        sb_q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    // One write: inputs change on the falling edge, commit on the next rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.write     = 1'b1;
        bus.rd        = a;
        bus.reg_write = d;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        logic [31:0] k;
        k = 32'h0101_0101;
        return (i == 0) ? 32'h0 : k * 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.write     = 1'b1;   // write attempted during reset, must be dropped
        bus.rd        = 5'd1;
        bus.reg_write = 32'h5555_5555;
        bus.rs1       = 5'd1;
        bus.rs2       = 5'd31;

        // Power-on reset held for 2 cycles
        repeat (2) @(negedge clk);
        #1 expect_rd("reset_hold", 32'h0, 32'h0);
        bus.write = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1 expect_rd("after_reset", 32'h0, 32'h0);

        // Basic write/read, with pre-edge check (no bypass)
        @(negedge clk);
        bus.write     = 1'b1;
        bus.rd        = 5'd1;
        bus.reg_write = 32'hDEAD_BEEF;
        bus.rs1       = 5'd1;
        bus.rs2       = 5'd1;
        #1 expect_rd("pre_edge_no_bypass", 32'h0, 32'h0);
        @(negedge clk);
        bus.write = 1'b0;
        #1 expect_rd("basic_wr_rd", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // x0 hardwired
        wr(5'd0, 32'hFFFF_FFFF);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        #1 expect_rd("x0_zero", 32'h0, 32'h0);

        // Write-enable gating
        wr(5'd5, 32'h1234_5678);
        @(negedge clk);
        bus.write     = 1'b0;
        bus.rd        = 5'd5;
        bus.reg_write = 32'hAAAA_AAAA;
        repeat (2) @(negedge clk);
        bus.rs1 = 5'd1;
        bus.rs2 = 5'd5;
        #1 expect_rd("we_gating", 32'hDEAD_BEEF, 32'h1234_5678);

        // Fill all registers, then sweep both ports in opposite directions
        for (int i = 1; i < 32; i++) wr(5'(i), sweep_val(i));
        for (int i = 0; i < 32; i++) begin
            bus.rs1 = 5'(i);
            bus.rs2 = 5'(31 - i);
            #1 expect_rd($sformatf("sweep_%0d", i), sweep_val(i), sweep_val(31 - i));
        end

        // Async reset mid-operation, with a write pending across the edge
        wr(5'd7, 32'h0000_00FF);
        bus.rs1 = 5'd7;
        bus.rs2 = 5'd3;
        #1 expect_rd("x7_loaded", 32'h0000_00FF, sweep_val(3));
        @(posedge clk);
        #2;
        bus.write     = 1'b1;
        bus.rd        = 5'd7;
        bus.reg_write = 32'h7777_7777;
        rst = 1'b0;
        #1 expect_rd("async_reset_drop", 32'h0, 32'h0);
        @(negedge clk);
        bus.write = 1'b0;
        rst = 1'b1;
        #1 expect_rd("write_in_reset_dropped", 32'h0, 32'h0);

        // Writes resume after reset release
        wr(5'd3, 32'hCAFE_F00D);
        #1 expect_rd("write_after_reset", 32'h0, 32'hCAFE_F00D);

        #5;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_file.md
# register_file

32-entry × 32-bit general-purpose register file for the RV32I core, two combinational read ports and one synchronous write port. Register x0 is hardwired to zero. Sits between decode (rs1/rs2/rd fields) and the ALU/writeback path. Single-cycle core, so there is no internal pipelining and no forwarding logic.

## Interface
Parameters:
- DATA_WIDTH, default 32: register width in bits.
- ADDR_WIDTH, default 5: address width; depth is 2**ADDR_WIDTH = 32 entries.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset; 0 clears every register.
- write, input, 1: write enable for the write port.
- rd, input, ADDR_WIDTH: write-port register index.
- reg_write, input, DATA_WIDTH: data to write into register rd.
- rs1, input, ADDR_WIDTH: read-port 1 register index.
- rs2, input, ADDR_WIDTH: read-port 2 register index.
- reg1, output, DATA_WIDTH: contents of register rs1.
- reg2, output, DATA_WIDTH: contents of register rs2.

## Operation
- Storage is 32 registers, x0..x31, each DATA_WIDTH bits.
- Reset:
  - rst = 0 immediately clears all registers to 0, with no clock needed.
  - While rst = 0, reg1 and reg2 read 0 for every address.
  - Writes are ignored while rst = 0.
- Write:
  - Occurs on a rising clk edge when rst = 1, write = 1 and rd ≠ 0.
  - The full reg_write value is stored into register rd.
  - write = 0 leaves all registers unchanged.
- x0:
  - A write with rd = 0 is discarded.
  - rs1 = 0 or rs2 = 0 always returns 32'h0000_0000.
- Read:
  - Purely combinational: reg1 = regs[rs1] and reg2 = regs[rs2].
  - Outputs change within the same cycle that rs1 or rs2 change.
- Both read ports are independent. rs1 = rs2 is legal and both outputs show the same value.
- No bypass: when rd equals rs1 or rs2 during a write cycle, the outputs show the old value until the edge, then the new value.
- No X propagation: every register holds a defined value after the first reset.

## Timing
- Read latency is 0 cycles (combinational from rs1/rs2 and the register array).
- Write latency is 1 edge; the new value appears on reg1/reg2 right after the rising edge that commits it.
- Reset assertion is asynchronous. Outputs go to 0 within the same delta/combinational settle, independent of clk.
- Reset deassertion (rst 0→1) must meet recovery/removal timing to clk. The first possible write is the first rising edge with rst = 1.
- Reset asserted mid-write cycle: reset wins, the register is cleared and the pending write is dropped.
- Simultaneous write and read of the same register: the read returns the pre-edge value before the edge and the post-edge value after it.
- Inputs rd, reg_write and write must be stable around the rising clk edge (standard setup/hold).

## Test plan
- Power-on reset:
  - Stimulus: drive rst = 0 for 2 cycles, with rs1 = 1 and rs2 = 31.
  - Required: reg1 = 0 and reg2 = 0. After rst = 1 with no writes, both still read 0.
- Basic write/read:
  - Stimulus: rst = 1, write = 1, rd = 1, reg_write = 32'hDEAD_BEEF for one edge, then write = 0, rs1 = 1, rs2 = 1.
  - Required: reg1 = reg2 = 32'hDEAD_BEEF. Before that edge, reg1 = 0.
- x0 hardwired:
  - Stimulus: write = 1, rd = 0, reg_write = 32'hFFFF_FFFF, one edge, then rs1 = 0.
  - Required: reg1 = 0.
- Write-enable gating:
  - Stimulus: x5 = 32'h1234_5678, then write = 0, rd = 5, reg_write = 32'hAAAA_AAAA for 2 edges.
  - Required: rs2 = 5 gives reg2 = 32'h1234_5678.
- Dual read and all addresses:
  - Stimulus: write x(i) = i × 32'h0101_0101 for i = 1..31, then sweep rs1 = i and rs2 = 31 − i.
  - Required: each port returns its own register's value, with 0 for x0.
- Async reset mid-operation:
  - Stimulus: with x7 = 32'h0000_00FF, assert rst = 0 between clock edges.
  - Required: reg1 (rs1 = 7) drops to 0 before the next edge. A write issued during reset does not take effect.
